// File: rtl/red_pitaya_pfd_pkg.sv
// rtl/red_pitaya_pfd_pkg.sv - shared types and defaults for the phase-frequency detector path
package red_pitaya_pfd_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_TRACK  = 2'd1,
        ST_FROZEN = 2'd2
    } pfd_state_e;

    localparam int PFD_PHASEWIDTH = 10;
    localparam int PFD_SIGNALBITS = 14;

endpackage

// File: rtl/red_pitaya_pfd_unwrap_if.sv
// rtl/red_pitaya_pfd_unwrap_if.sv - phase sample in / integral out bundle of the unwrap integrator
interface red_pitaya_pfd_unwrap_if
    import red_pitaya_pfd_pkg::*;
#(
    parameter int PHASEWIDTH = PFD_PHASEWIDTH,
    parameter int SIGNALBITS = PFD_SIGNALBITS
);
    logic        [PHASEWIDTH-1:0] phase_i;
    logic                         phase_valid_i;
    logic                         hold_i;
    logic                         clear_i;
    logic signed [SIGNALBITS-1:0] integral_o;
    logic                         valid_o;
    logic        [1:0]            sat_o;

    modport master (
        output phase_i, phase_valid_i, hold_i, clear_i,
        input  integral_o, valid_o, sat_o
    );

    modport slave (
        input  phase_i, phase_valid_i, hold_i, clear_i,
        output integral_o, valid_o, sat_o
    );
endinterface

// File: rtl/red_pitaya_pfd_satround.sv
// rtl/red_pitaya_pfd_satround.sv - registered round-half-up arithmetic shift with signed saturation
module red_pitaya_pfd_satround #(
    parameter int IW    = 24,
    parameter int SHIFT = 4,
    parameter int OW    = 14
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic signed [IW-1:0] data_i,
    output logic signed [OW-1:0] data_o
);
    // Compare in a width that holds both the shifted value and the output limits.
    localparam int W = IW + OW + 1;
    localparam logic signed [IW:0]  HALF = (IW+1)'(2 ** (SHIFT-1));
    localparam logic signed [W-1:0] MAXV = W'((2 ** (OW-1)) - 1);
    localparam logic signed [W-1:0] MINV = -MAXV - W'(1);

    logic signed [IW:0]   sum_d;
    logic signed [IW:0]   shr_d;
    logic signed [W-1:0]  wide_d;
    logic signed [OW-1:0] sat_d;
    logic signed [OW-1:0] out_q;

    always_comb begin
        sum_d  = $signed({data_i[IW-1], data_i}) + HALF;
        shr_d  = sum_d >>> SHIFT;
        wide_d = {{(W-IW-1){shr_d[IW]}}, shr_d};
        if (wide_d > MAXV) begin
            sat_d = MAXV[OW-1:0];
        end else if (wide_d < MINV) begin
            sat_d = MINV[OW-1:0];
        end else begin
            sat_d = wide_d[OW-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_q <= '0;
        end else if (clr_i) begin
            out_q <= '0;
        end else if (en_i) begin
            out_q <= sat_d;
        end
    end

    assign data_o = out_q;
endmodule

// File: rtl/red_pitaya_pfd_unwrap.sv
// rtl/red_pitaya_pfd_unwrap.sv - wrap-aware phase difference integrator, three registered stages
module red_pitaya_pfd_unwrap
    import red_pitaya_pfd_pkg::*;
#(
    parameter int PHASEWIDTH = PFD_PHASEWIDTH,
    parameter int ACCWIDTH   = 24,
    parameter int SHIFT      = 4,
    parameter int SIGNALBITS = PFD_SIGNALBITS
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    red_pitaya_pfd_unwrap_if.slave  bus
);
    pfd_state_e                     state_q;
    logic        [PHASEWIDTH-1:0]   last_phase_q;
    logic        [PHASEWIDTH-1:0]   delta_d;
    logic signed [PHASEWIDTH-1:0]   delta_q;
    logic                           v1_q;
    logic                           acc_en1_q;

    logic signed [ACCWIDTH:0]       acc_sum_d;
    logic signed [ACCWIDTH-1:0]     acc_q;
    logic        [1:0]              sat_q;
    logic                           v2_q;

    logic                           valid_q;
    logic signed [SIGNALBITS-1:0]   integral_w;

    // Modular subtraction; the signed reinterpretation picks the shortest way round.
    assign delta_d = bus.phase_i - last_phase_q;

    // S1: state machine, phase history and delta
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_EMPTY;
            last_phase_q <= '0;
            delta_q      <= '0;
            v1_q         <= 1'b0;
            acc_en1_q    <= 1'b0;
        end else if (bus.clear_i) begin
            state_q      <= ST_EMPTY;
            last_phase_q <= '0;
            v1_q         <= 1'b0;
            acc_en1_q    <= 1'b0;
        end else begin
            v1_q <= 1'b0;
            case (state_q)
                ST_EMPTY: begin
                    if (bus.phase_valid_i) begin
                        last_phase_q <= bus.phase_i;
                        state_q      <= bus.hold_i ? ST_FROZEN : ST_TRACK;
                    end
                end
                ST_TRACK, ST_FROZEN: begin
                    state_q <= bus.hold_i ? ST_FROZEN : ST_TRACK;
                    if (bus.phase_valid_i) begin
                        last_phase_q <= bus.phase_i;
                        delta_q      <= $signed(delta_d);
                        v1_q         <= 1'b1;
                        acc_en1_q    <= !bus.hold_i;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign acc_sum_d = {acc_q[ACCWIDTH-1], acc_q}
                     + {{(ACCWIDTH+1-PHASEWIDTH){delta_q[PHASEWIDTH-1]}}, delta_q};

    // S2: accumulate; the two top bits of the extended sum disagree only on overflow
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_q <= '0;
            sat_q <= 2'b00;
            v2_q  <= 1'b0;
        end else if (bus.clear_i) begin
            acc_q <= '0;
            sat_q <= 2'b00;
            v2_q  <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q && acc_en1_q) begin
                case (acc_sum_d[ACCWIDTH:ACCWIDTH-1])
                    2'b01: begin
                        acc_q    <= {1'b0, {(ACCWIDTH-1){1'b1}}};
                        sat_q[0] <= 1'b1;
                    end
                    2'b10: begin
                        acc_q    <= {1'b1, {(ACCWIDTH-1){1'b0}}};
                        sat_q[1] <= 1'b1;
                    end
                    default: acc_q <= acc_sum_d[ACCWIDTH-1:0];
                endcase
            end
        end
    end

    // S3: round, saturate and present the error signal
    red_pitaya_pfd_satround #(
        .IW    (ACCWIDTH),
        .SHIFT (SHIFT),
        .OW    (SIGNALBITS)
    ) u_satround (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (bus.clear_i),
        .en_i   (v2_q),
        .data_i (acc_q),
        .data_o (integral_w)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= v2_q && !bus.clear_i;
        end
    end

    assign bus.integral_o = integral_w;
    assign bus.valid_o    = valid_q;
    assign bus.sat_o      = sat_q;
endmodule

// File: tb/tb_red_pitaya_pfd_unwrap.sv
// tb/tb_red_pitaya_pfd_unwrap.sv - bench for the phase unwrap integrator against a timeline model
module tb_red_pitaya_pfd_unwrap;
    localparam int PW   = 10;
    localparam int AW   = 16;
    localparam int SH   = 4;
    localparam int SB   = 14;
    localparam int MAXC = 2048;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    red_pitaya_pfd_unwrap_if #(.PHASEWIDTH(PW), .SIGNALBITS(SB)) bus ();

    red_pitaya_pfd_unwrap #(
        .PHASEWIDTH (PW),
        .ACCWIDTH   (AW),
        .SHIFT      (SH),
        .SIGNALBITS (SB)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: unwrapped phase sum plus a timeline of when each effect becomes visible.
    bit         have_prev = 0;
    int         last_ph   = 0;
    int         acc       = 0;
    logic [1:0] msat      = 2'b00;
    bit         vld  [MAXC];
    bit         iset [MAXC];
    int         ival [MAXC];
    bit         sset [MAXC];
    logic [1:0] sval [MAXC];
    bit         exp_vld = 0;
    int         exp_int = 0;
    logic [1:0] exp_sat = 2'b00;

    function automatic int out_of(int a);
        int x = a + (1 << (SH-1));
        int r = (x >= 0) ? x / (1 << SH) : -((-x + (1 << SH) - 1) / (1 << SH));
        int lim = 1 << (SB-1);
        if (r > lim - 1) r = lim - 1;
        if (r < -lim) r = -lim;
        return r;
    endfunction

    task automatic model_clear();
        have_prev = 0; last_ph = 0; acc = 0; msat = 2'b00;
        for (int j = cyc; j <= cyc + 2; j++) begin
            vld[j] = 0; iset[j] = 0; sset[j] = 0;
        end
        iset[cyc] = 1; ival[cyc] = 0;
        sset[cyc] = 1; sval[cyc] = 2'b00;
    endtask

    task automatic model_sample(int p, bit h);
        int d;
        if (!have_prev) begin
            have_prev = 1; last_ph = p;
            return;
        end
        d = (p - last_ph + (1 << PW)) % (1 << PW);
        if (d >= (1 << (PW-1))) d = d - (1 << PW);
        last_ph = p;
        if (!h) begin
            acc = acc + d;
            if (acc > (1 << (AW-1)) - 1) begin acc = (1 << (AW-1)) - 1; msat[0] = 1'b1; end
            if (acc < -(1 << (AW-1)))    begin acc = -(1 << (AW-1));    msat[1] = 1'b1; end
        end
        sset[cyc+1] = 1; sval[cyc+1] = msat;
        vld[cyc+2]  = 1;
        iset[cyc+2] = 1; ival[cyc+2] = out_of(acc);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rstn || bus.clear_i) model_clear();
        else if (bus.phase_valid_i) model_sample(int'(bus.phase_i), bus.hold_i);
        #1;
        exp_vld = vld[cyc];
        if (iset[cyc]) exp_int = ival[cyc];
        if (sset[cyc]) exp_sat = sval[cyc];
    endtask

    task automatic drive(bit v, int p, bit h, bit c);
        bus.phase_valid_i = v;
        bus.phase_i       = p[PW-1:0];
        bus.hold_i        = h;
        bus.clear_i       = c;
        tick();
        bus.phase_valid_i = 1'b0;
        bus.clear_i       = 1'b0;
    endtask

    task automatic test_reset();
        int got;
        bus.phase_valid_i = 0; bus.phase_i = '0; bus.hold_i = 0; bus.clear_i = 0;
        rstn = 1'b0;
        tick(); tick();
        got = bus.integral_o;
        n_tests += 3;
        if (got !== 0)             begin n_fail++; $display("FAIL reset_integral got %0d want 0", got); end
        if (bus.sat_o !== 2'b00)   begin n_fail++; $display("FAIL reset_sat got %b want 00", bus.sat_o); end
        if (bus.valid_o !== 1'b0)  begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.valid_o); end
        rstn = 1'b1;
        drive(1, 300, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0);
            n_tests++;
            if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL prime_no_valid got %b want 0 cyc %0d", bus.valid_o, cyc); end
        end
    endtask

    task automatic test_constant_rotation();
        int got;
        int pulses = 0;
        drive(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1, i * 100, 0, 0);
            if (bus.valid_o === 1'b1) pulses++;
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0);
            if (bus.valid_o === 1'b1) pulses++;
            got = bus.integral_o;
            n_tests += 2;
            if (bus.valid_o !== exp_vld) begin n_fail++; $display("FAIL rot_valid got %b want %b cyc %0d", bus.valid_o, exp_vld, cyc); end
            if (got !== exp_int)         begin n_fail++; $display("FAIL rot_integral got %0d want %0d cyc %0d", got, exp_int, cyc); end
        end
        got = bus.integral_o;
        n_tests += 2;
        if (pulses !== 4) begin n_fail++; $display("FAIL rot_pulses got %0d want 4", pulses); end
        if (got !== 25)   begin n_fail++; $display("FAIL rot_final got %0d want 25", got); end
    endtask

    task automatic test_wrap_and_half_turn();
        int got;
        drive(0, 0, 0, 1);
        drive(1, 1000, 0, 0);
        drive(1, 20, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        got = bus.integral_o;
        n_tests++;
        if (got !== 3) begin n_fail++; $display("FAIL wrap_fwd got %0d want 3", got); end
        drive(1, 20, 0, 0);
        drive(1, 1000, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        got = bus.integral_o;
        n_tests += 2;
        if (got !== 0)       begin n_fail++; $display("FAIL wrap_net got %0d want 0", got); end
        if (got !== exp_int) begin n_fail++; $display("FAIL wrap_model got %0d want %0d", got, exp_int); end
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 0);
        drive(1, 512, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        got = bus.integral_o;
        n_tests++;
        if (got !== -32) begin n_fail++; $display("FAIL half_turn got %0d want -32", got); end
    endtask

    task automatic test_saturation();
        int got;
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 0);
        for (int k = 1; k <= 80; k++) begin
            drive(1, (500 * k) % 1024, 0, 0);
            got = bus.integral_o;
            n_tests += 3;
            if (bus.valid_o !== exp_vld) begin n_fail++; $display("FAIL sat_valid got %b want %b cyc %0d", bus.valid_o, exp_vld, cyc); end
            if (got !== exp_int)         begin n_fail++; $display("FAIL sat_integral got %0d want %0d cyc %0d", got, exp_int, cyc); end
            if (bus.sat_o !== exp_sat)   begin n_fail++; $display("FAIL sat_flags got %b want %b cyc %0d", bus.sat_o, exp_sat, cyc); end
        end
        repeat (3) drive(0, 0, 0, 0);
        got = bus.integral_o;
        n_tests += 2;
        if (bus.sat_o !== 2'b01) begin n_fail++; $display("FAIL sat_final_flags got %b want 01", bus.sat_o); end
        if (got !== 2048)        begin n_fail++; $display("FAIL sat_final got %0d want 2048", got); end
        drive(0, 0, 0, 1);
        got = bus.integral_o;
        n_tests += 2;
        if (bus.sat_o !== 2'b00) begin n_fail++; $display("FAIL clr_flags got %b want 00", bus.sat_o); end
        if (got !== 0)           begin n_fail++; $display("FAIL clr_integral got %0d want 0", got); end
        drive(1, 5, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0);
            n_tests++;
            if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL clr_reprime got %b want 0 cyc %0d", bus.valid_o, cyc); end
        end
    endtask

    task automatic test_hold_clear();
        int got;
        int pulses = 0;
        drive(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, i * 200, 1, 0);
            if (bus.valid_o === 1'b1) pulses++;
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0);
            if (bus.valid_o === 1'b1) pulses++;
            got = bus.integral_o;
            n_tests++;
            if (got !== 0) begin n_fail++; $display("FAIL hold_frozen got %0d want 0 cyc %0d", got, cyc); end
        end
        n_tests++;
        if (pulses !== 3) begin n_fail++; $display("FAIL hold_pulses got %0d want 3", pulses); end
        drive(1, 800, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        got = bus.integral_o;
        n_tests++;
        if (got !== 13) begin n_fail++; $display("FAIL hold_release got %0d want 13", got); end
        drive(1, 900, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0);
            got = bus.integral_o;
            n_tests += 2;
            if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL clr_drop_valid got %b want 0 cyc %0d", bus.valid_o, cyc); end
            if (got !== 0)            begin n_fail++; $display("FAIL clr_drop_int got %0d want 0 cyc %0d", got, cyc); end
        end
    endtask

    task automatic test_back_to_back_random();
        int got;
        drive(0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1023),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
            got = bus.integral_o;
            n_tests += 3;
            if (bus.valid_o !== exp_vld) begin n_fail++; $display("FAIL rnd_valid got %b want %b cyc %0d", bus.valid_o, exp_vld, cyc); end
            if (got !== exp_int)         begin n_fail++; $display("FAIL rnd_integral got %0d want %0d cyc %0d", got, exp_int, cyc); end
            if (bus.sat_o !== exp_sat)   begin n_fail++; $display("FAIL rnd_sat got %b want %b cyc %0d", bus.sat_o, exp_sat, cyc); end
        end
    endtask

    task automatic test_reset_midway();
        int got;
        int pulses = 0;
        for (int i = 0; i < 6; i++) drive(1, $urandom_range(0, 1023), 0, 0);
        #2 rstn = 1'b0;
        #1;
        got = bus.integral_o;
        n_tests += 3;
        if (got !== 0)            begin n_fail++; $display("FAIL midrst_integral got %0d want 0", got); end
        if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", bus.valid_o); end
        if (bus.sat_o !== 2'b00)  begin n_fail++; $display("FAIL midrst_sat got %b want 00", bus.sat_o); end
        tick(); tick();
        rstn = 1'b1;
        drive(1, 100, 0, 0);
        drive(1, 150, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0);
            if (bus.valid_o === 1'b1) pulses++;
            got = bus.integral_o;
            n_tests += 2;
            if (bus.valid_o !== exp_vld) begin n_fail++; $display("FAIL post_rst_valid got %b want %b cyc %0d", bus.valid_o, exp_vld, cyc); end
            if (got !== exp_int)         begin n_fail++; $display("FAIL post_rst_int got %0d want %0d cyc %0d", got, exp_int, cyc); end
        end
        got = bus.integral_o;
        n_tests += 2;
        if (pulses !== 1) begin n_fail++; $display("FAIL post_rst_pulses got %0d want 1", pulses); end
        if (got !== 3)    begin n_fail++; $display("FAIL post_rst_final got %0d want 3", got); end
    endtask

    initial begin
        test_reset();
        test_constant_rotation();
        test_wrap_and_half_turn();
        test_saturation();
        test_hold_clear();
        test_back_to_back_random();
        test_reset_midway();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
